// File: rtl/load_store_unit.sv
// load_store_unit -- MEM-stage initiator for a word-organised, byte-enabled
// data memory with a req/ack handshake and wait states.
//
// Ports
//   clk, reset         rising-edge clock, synchronous active-high reset
//   MemRead, MemWrite  load / store request (MemRead wins if both set)
//   Funct3             access size and sign (instr[14:12])
//   a                  byte address
//   wd                 store data
//   rd                 formatted load data, valid in DONE, held until the
//                      next load completes (zeroed on an error)
//   stall              holds the pipeline while an access is pending
//   lsu_err            one-cycle pulse in DONE on timeout or misalign
//   mem_req .. mem_wdata  registered memory request fields
//   mem_ack, mem_rdata memory completion and read word (same cycle)
//   dbg_state          current FSM state, for observation only
//
// Handshake: mem_req rises on the edge that leaves IDLE and stays high until
// the edge that samples mem_ack=1 (or the wait budget runs out). mem_addr,
// mem_we, mem_be and mem_wdata are stable for the whole time mem_req is high.
//
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned halfword
// and word accesses (no memory request, lsu_err pulse, rd=0). Without it the
// ignored low address bits are treated as zero.

module load_store_unit #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int MAX_WAIT   = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [DM_ADDRESS-1:0] a,
  input  logic [DATA_W-1:0]     wd,
  output logic [DATA_W-1:0]     rd,
  output logic                  stall,
  output logic                  lsu_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [1:0]            dbg_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [1:0]        state;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic              is_load_q;
  logic [CW-1:0]     wait_cnt;

  logic              req_any;
  logic              misalign;
  logic [3:0]        st_be;
  logic [DATA_W-1:0] st_wdata;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_data;
  logic              last_wait;

  assign req_any   = MemRead | MemWrite;
  assign dbg_state = state;
  assign last_wait = (wait_cnt == CW'(MAX_WAIT - 1));

  // IDLE requests stall combinationally so the instruction is held on the
  // very cycle it asks; ACCESS keeps stalling; DONE releases the pipeline.
  always_comb begin
    stall = 1'b0;
    case (state)
      S_IDLE:   stall = req_any;
      S_ACCESS: stall = 1'b1;
      default:  stall = 1'b0;
    endcase
  end

  always_comb begin
    misalign = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (MemRead) begin
      case (Funct3)
        3'b001, 3'b101: misalign = a[0];
        3'b010:         misalign = |a[1:0];
        default:        misalign = 1'b0;
      endcase
    end else if (MemWrite) begin
      case (Funct3)
        3'b001:  misalign = a[0];
        3'b010:  misalign = |a[1:0];
        default: misalign = 1'b0;
      endcase
    end
`endif
  end

  // Store lanes: narrow data is replicated across the word so the memory
  // only needs the byte enables to pick the right lane.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = wd;
    case (Funct3)
      3'b000: begin
        st_be    = 4'b0001 << a[1:0];
        st_wdata = {4{wd[7:0]}};
      end
      3'b001: begin
        st_be    = a[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{wd[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = wd;
      end
    endcase
  end

  // Load alignment uses the offset captured at request time, since the
  // pipeline may already be presenting a different address by the ack.
  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (off_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{(DATA_W-16){ld_half[15]}}, ld_half};
      3'b100:  ld_data = {{(DATA_W-8){1'b0}}, ld_byte};
      3'b101:  ld_data = {{(DATA_W-16){1'b0}}, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
      is_load_q <= 1'b0;
      wait_cnt  <= '0;
      rd        <= '0;
      lsu_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'b0000;
      mem_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_any) begin
            f3_q      <= Funct3;
            off_q     <= a[1:0];
            is_load_q <= MemRead;
            if (misalign) begin
              // Trapped access never reaches the memory.
              state   <= S_DONE;
              lsu_err <= 1'b1;
              rd      <= '0;
            end else begin
              state     <= S_ACCESS;
              mem_req   <= 1'b1;
              mem_we    <= ~MemRead;
              mem_addr  <= {a[DM_ADDRESS-1:2], 2'b00};
              mem_be    <= MemRead ? 4'b0000 : st_be;
              mem_wdata <= st_wdata;
            end
          end
        end
        S_ACCESS: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (mem_ack) begin
            // An ack on the final budgeted cycle still counts as success.
            state   <= S_DONE;
            mem_req <= 1'b0;
            if (is_load_q) rd <= ld_data;
          end else if (last_wait) begin
            state   <= S_DONE;
            mem_req <= 1'b0;
            lsu_err <= 1'b1;
            rd      <= '0;
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          lsu_err  <= 1'b0;
          wait_cnt <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit. A transaction-level model predicts,
// per cycle of each transaction, stall / mem_req / request fields / lsu_err,
// and an expected-rd queue is consumed in each DONE cycle. Spec vectors are
// additionally pinned with hand-computed literals.

module tb_load_store_unit;

  localparam int MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [8:0]  a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        stall, lsu_err;
  logic        mem_req, mem_we;
  logic [8:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;

  load_store_unit #(.DM_ADDRESS(9), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Funct3(Funct3), .a(a), .wd(wd), .rd(rd), .stall(stall),
    .lsu_err(lsu_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd = 32'h0;

  bit          tb_active = 1'b0;
  int          tb_k = -1;
  int          cur_n;
  bit          cur_err, cur_st;
  logic [8:0]  cur_addr;
  logic [3:0]  cur_be;
  logic [31:0] cur_wdata;
  logic [8:0]  obs_addr;
  logic [3:0]  obs_be;
  logic [31:0] obs_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // model helpers
  function automatic int ld_size(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic int st_size(input logic [2:0] f3);
    if (f3 == 3'b000) return 1;
    if (f3 == 3'b001) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f3, input int size,
                                           input int base, input logic [31:0] w);
    logic [31:0] v;
    bit          sgn;
    v   = w >> (8 * base);
    sgn = (f3[2] == 1'b0);
    if (size == 1) v = (sgn && v[7])  ? {24'hFFFFFF, v[7:0]}  : {24'h0, v[7:0]};
    if (size == 2) v = (sgn && v[15]) ? {16'hFFFF, v[15:0]}   : {16'h0, v[15:0]};
    return v;
  endfunction

  // compare process: every cycle while a directed transaction is in flight
  always @(negedge clk) begin
    if (tb_active) begin
      if (tb_k < 0) begin
        chk("idle_stall", {31'h0, stall}, 32'h0);
        chk("idle_req", {31'h0, mem_req}, 32'h0);
        chk("idle_err", {31'h0, lsu_err}, 32'h0);
      end else begin
        chk("stall", {31'h0, stall}, {31'h0, (tb_k <= cur_n)});
        chk("mem_req", {31'h0, mem_req}, {31'h0, (tb_k >= 1 && tb_k <= cur_n)});
        if (tb_k >= 1 && tb_k <= cur_n) begin
          chk("mem_we", {31'h0, mem_we}, {31'h0, cur_st});
          chk("mem_addr", {23'h0, mem_addr}, {23'h0, cur_addr});
          chk("mem_be", {28'h0, mem_be}, {28'h0, cur_be});
          if (cur_st) chk("mem_wdata", mem_wdata, cur_wdata);
          obs_addr  = mem_addr;
          obs_be    = mem_be;
          obs_wdata = mem_wdata;
        end
        if (tb_k == cur_n + 1) begin
          chk("lsu_err", {31'h0, lsu_err}, {31'h0, cur_err});
          if (exp_q.size() == 0) chk("exp_q_empty", 32'h1, 32'h0);
          else chk("rd", rd, exp_q.pop_front());
        end else begin
          chk("lsu_err_quiet", {31'h0, lsu_err}, 32'h0);
        end
      end
    end
  end

  // driver: op 0=load, 1=store, 2=both (load expected); d = ACCESS cycle of ack
  task automatic run_txn(input int op, input logic [2:0] t_f3, input logic [8:0] t_a,
                         input logic [31:0] t_wd, input logic [31:0] t_rdata, input int d,
                         input bit lit, input logic [31:0] lit_val, input logic [3:0] lit_be,
                         input logic [8:0] lit_addr);
    int          size, base, n;
    bit          st, mis, err;
    logic [31:0] erd, w;
    st   = (op == 1);
    size = st ? st_size(t_f3) : ld_size(t_f3);
    base = (int'(t_a[1:0]) / size) * size;
    mis  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((st && (t_f3 == 3'b001 || t_f3 == 3'b010)) ||
        (!st && (t_f3 == 3'b001 || t_f3 == 3'b101 || t_f3 == 3'b010)))
      mis = (int'(t_a[1:0]) % size) != 0;
`endif
    for (int i = 0; i < 4; i++) w[8*i +: 8] = t_wd[8*(i % size) +: 8];
    cur_st    = st;
    cur_addr  = {t_a[8:2], 2'b00};
    cur_be    = st ? 4'(((1 << size) - 1) << base) : 4'h0;
    cur_wdata = w;
    if (mis) begin
      n = 0; err = 1'b1; erd = 32'h0;
    end else if (d >= 1 && d <= MAX_WAIT) begin
      n = d; err = 1'b0; erd = st ? last_rd : load_val(t_f3, size, base, t_rdata);
    end else begin
      n = MAX_WAIT; err = 1'b1; erd = 32'h0;
    end
    last_rd = erd;
    exp_q.push_back(erd);
    cur_n   = n;
    cur_err = err;
    for (int k = 0; k <= n + 1; k++) begin
      @(posedge clk); #1;
      MemRead   = (op != 1);
      MemWrite  = (op != 0);
      Funct3    = t_f3;
      a         = t_a;
      wd        = t_wd;
      mem_rdata = t_rdata;
      mem_ack   = (k == d) && (k >= 1) && (k <= n) && !mis;
      tb_k      = k;
      tb_active = 1'b1;
    end
    if (lit) begin
      @(negedge clk);
      if (st && !mis) begin
        chk("lit_be", {28'h0, obs_be}, {28'h0, lit_be});
        chk("lit_wdata", obs_wdata, lit_val);
      end else begin
        chk("lit_rd", rd, lit_val);
      end
      if (!mis) chk("lit_addr", {23'h0, obs_addr}, {23'h0, lit_addr});
    end
    @(posedge clk); #1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    mem_ack  = 1'b0;
    tb_k     = -1;
  endtask

  initial begin
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b000;
    a = 9'h0; wd = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_rd", rd, 32'h0);
    chk("rst_req", {31'h0, mem_req}, 32'h0);
    chk("rst_we", {31'h0, mem_we}, 32'h0);
    chk("rst_be", {28'h0, mem_be}, 32'h0);
    chk("rst_addr", {23'h0, mem_addr}, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_err", {31'h0, lsu_err}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);

    // stores
    run_txn(1, 3'b010, 9'h010, 32'hDEADBEEF, 32'h0, 1, 1, 32'hDEADBEEF, 4'b1111, 9'h010);
    run_txn(1, 3'b000, 9'h013, 32'h000000A5, 32'h0, 1, 1, 32'hA5A5A5A5, 4'b1000, 9'h010);
    run_txn(1, 3'b001, 9'h012, 32'h00001234, 32'h0, 2, 1, 32'h12341234, 4'b1100, 9'h010);
    run_txn(1, 3'b000, 9'h021, 32'h0000003C, 32'h0, 1, 1, 32'h3C3C3C3C, 4'b0010, 9'h020);

    // loads from the word 0x80F17F05 at 0x0C
    run_txn(0, 3'b000, 9'h00D, 32'h0, 32'h80F17F05, 1, 1, 32'h0000007F, 4'h0, 9'h00C);
    run_txn(0, 3'b000, 9'h00E, 32'h0, 32'h80F17F05, 1, 1, 32'hFFFFFFF1, 4'h0, 9'h00C);
    run_txn(0, 3'b100, 9'h00F, 32'h0, 32'h80F17F05, 1, 1, 32'h00000080, 4'h0, 9'h00C);
    run_txn(0, 3'b001, 9'h00E, 32'h0, 32'h80F17F05, 2, 1, 32'hFFFF80F1, 4'h0, 9'h00C);
    run_txn(0, 3'b101, 9'h00E, 32'h0, 32'h80F17F05, 1, 1, 32'h000080F1, 4'h0, 9'h00C);
    run_txn(0, 3'b000, 9'h00C, 32'h0, 32'h80F17F05, 1, 1, 32'h00000005, 4'h0, 9'h00C);
    // delayed ack: mem_req 3 cycles, stall 4 cycles
    run_txn(0, 3'b010, 9'h00C, 32'h0, 32'h80F17F05, 3, 1, 32'h80F17F05, 4'h0, 9'h00C);

    // a store leaves rd untouched
    run_txn(1, 3'b010, 9'h030, 32'h01020304, 32'h0, 1, 0, 32'h0, 4'h0, 9'h0);
    // both requests set: load wins
    run_txn(2, 3'b100, 9'h041, 32'hFFFFFFFF, 32'h00009A00, 1, 1, 32'h0000009A, 4'h0, 9'h040);

    // timeout and ack exactly on the last budgeted cycle
    run_txn(0, 3'b010, 9'h020, 32'h0, 32'h55555555, 99, 1, 32'h00000000, 4'h0, 9'h020);
    run_txn(1, 3'b010, 9'h024, 32'hCAFEF00D, 32'h0, MAX_WAIT, 0, 32'h0, 4'h0, 9'h0);
    run_txn(0, 3'b001, 9'h00C, 32'h0, 32'h80F17F05, MAX_WAIT, 1, 32'h00007F05, 4'h0, 9'h00C);

    // misaligned word / halfword
`ifdef LSU_MISALIGN_TRAP_EN
    run_txn(0, 3'b010, 9'h006, 32'h0, 32'h11223344, 1, 1, 32'h00000000, 4'h0, 9'h004);
    run_txn(1, 3'b001, 9'h013, 32'h0000BEEF, 32'h0, 1, 0, 32'h0, 4'h0, 9'h0);
`else
    run_txn(0, 3'b010, 9'h006, 32'h0, 32'h11223344, 1, 1, 32'h11223344, 4'h0, 9'h004);
    run_txn(1, 3'b001, 9'h013, 32'h0000BEEF, 32'h0, 1, 1, 32'hBEEFBEEF, 4'b1100, 9'h010);
`endif

    // reset in the second ACCESS cycle, then a late ack
    tb_active = 1'b0;
    @(posedge clk); #1;
    MemRead = 1'b1; Funct3 = 3'b010; a = 9'h040; mem_rdata = 32'h77777777;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("pre_rst_req", {31'h0, mem_req}, 32'h1);
    chk("pre_rst_stall", {31'h0, stall}, 32'h1);
    @(posedge clk); #1;
    reset = 1'b0; MemRead = 1'b0; mem_ack = 1'b1;
    @(negedge clk);
    chk("mid_rst_req", {31'h0, mem_req}, 32'h0);
    chk("mid_rst_stall", {31'h0, stall}, 32'h0);
    chk("mid_rst_rd", rd, 32'h0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_req", {31'h0, mem_req}, 32'h0);
    chk("late_ack_err", {31'h0, lsu_err}, 32'h0);
    chk("late_ack_rd", rd, 32'h0);
    last_rd = 32'h0;

    // normal operation resumes
    run_txn(0, 3'b100, 9'h043, 32'h0, 32'hC0000000, 1, 1, 32'h000000C0, 4'h0, 9'h040);
    run_txn(1, 3'b000, 9'h040, 32'h000000E7, 32'h0, 2, 1, 32'hE7E7E7E7, 4'b0001, 9'h040);

    repeat (2) @(posedge clk);
    tb_active = 1'b0;
    if (exp_q.size() != 0) chk("exp_q_drained", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
